instruction_sequencer: RTL and testbench

// - Fetch/step controller sitting directly upstream of instruction_decoder: owns the PC,

---
 rtl/instruction_sequencer_pkg.sv | 21 ++
 rtl/instruction_sequencer.sv | 123 ++++++++++++
 tb/tb_instruction_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the fetch/step controller: FSM state encodings, PC increment
// and the JAL offset helper.
package instruction_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // JAL immediate arrives as offset[20:1]; rebuild the byte offset and sign-extend from bit 19.
  function automatic logic [31:0] jal_offset(input logic [19:0] im20);
    return {{11{im20[19]}}, im20, 1'b0};
  endfunction

endpackage

// File: rtl/instruction_sequencer.sv
// Fetch/step controller: owns PC and IR, sequences FETCH/WAIT/DECODE/EXEC, 3+MEM_LAT+cnt_set
// cycles per instruction; no backpressure, run is sampled only at instruction boundaries.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic [1:0]  cnt_set,
  input  logic        stop,
  input  logic        ins_JAL,
  input  logic [31:0] IM,
  output logic [1:0]  step,
  output logic        exec_en,
  output logic [31:0] pc,
  output logic [31:0] pc_link,
  output logic        retire,
  output logic        halted
);

  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  wait_q, wait_d;
  logic [31:0] pc_next;
  logic        last_step;

  // Only the 20-bit JAL field of the immediate matters here.
  logic unused_im;
  assign unused_im = ^IM[31:20];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  assign last_step = (step_q == cnt_q);
  assign pc_next   = ins_JAL ? (pc_q + jal_offset(IM[19:0])) : (pc_q + PC_STEP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        wait_d  = WAIT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == 2'd0) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      ST_DECODE: begin
        if (stop) begin
          state_d = ST_HALT;
        end else begin
          step_d  = '0;
          cnt_d   = cnt_set;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (last_step) begin
          pc_d    = pc_next;
          step_d  = '0;
          state_d = run ? ST_FETCH : ST_IDLE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_rd_en = (state_q == ST_FETCH);
    exec_en    = (state_q == ST_EXEC);
    retire     = (state_q == ST_EXEC) && last_step;
    halted     = (state_q == ST_HALT);
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_link   = pc_q + PC_STEP;
  assign ir        = ir_q;
  assign step      = step_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: a MEM_LAT=1 instance runs small programs through a toy decoder,
// a MEM_LAT=3 instance covers long-latency timing and reset during WAIT.
module tb_instruction_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_ret = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Toy decoder: 0x33 = ALU op with cnt_set in [9:8], 0x6F = JAL with imm in [31:12].
  function automatic logic [1:0] dec_cnt(input logic [31:0] w);
    return w[9:8];
  endfunction
  function automatic logic dec_jal(input logic [31:0] w);
    return w[6:0] == 7'h6F;
  endfunction
  function automatic logic dec_stop(input logic [31:0] w);
    return !(w[6:0] == 7'h33 || w[6:0] == 7'h6F);
  endfunction
  function automatic logic [31:0] dec_im(input logic [31:0] w);
    return {{12{w[31]}}, w[31:12]};
  endfunction
  function automatic logic [31:0] op_add(input logic [1:0] c);
    return {22'd0, c, 1'b0, 7'h33};
  endfunction
  function automatic logic [31:0] op_jal(input logic [19:0] imm);
    return {imm, 5'd0, 7'h6F};
  endfunction

  // ---------------- MEM_LAT = 1 instance ----------------
  logic        rst = 1'b1, run = 1'b0;
  logic [31:0] imem_addr, imem_rdata, ir, im, pc, pc_link;
  logic        imem_rd_en, stop, ins_jal, exec_en, retire, halted;
  logic [1:0]  cnt_set, step;
  logic [31:0] mem [256];
  logic        pv1 = 1'b0;
  logic [31:0] pa1 = '0;

  assign cnt_set    = dec_cnt(ir);
  assign stop       = dec_stop(ir);
  assign ins_jal    = dec_jal(ir);
  assign im         = dec_im(ir);
  assign imem_rdata = pv1 ? mem[pa1[9:2]] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    pv1 <= imem_rd_en;
    pa1 <= imem_addr;
  end

  instruction_sequencer #(.PC_RESET(32'h0), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .ir(ir), .cnt_set(cnt_set), .stop(stop), .ins_JAL(ins_jal), .IM(im),
    .step(step), .exec_en(exec_en), .pc(pc), .pc_link(pc_link),
    .retire(retire), .halted(halted)
  );

  // ---------------- MEM_LAT = 3 instance ----------------
  logic        rst3 = 1'b1, run3 = 1'b0;
  logic [31:0] imem_addr3, imem_rdata3, ir3, im3, pc3, pc_link3;
  logic        imem_rd_en3, stop3, ins_jal3, exec_en3, retire3, halted3;
  logic [1:0]  cnt_set3, step3;
  logic [31:0] mem3 [16];
  logic [2:0]  pv3 = '0;
  logic [31:0] pa3 [3];

  assign cnt_set3    = dec_cnt(ir3);
  assign stop3       = dec_stop(ir3);
  assign ins_jal3    = dec_jal(ir3);
  assign im3         = dec_im(ir3);
  assign imem_rdata3 = pv3[2] ? mem3[pa3[2][5:2]] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    pv3    <= {pv3[1:0], imem_rd_en3};
    pa3[0] <= imem_addr3;
    pa3[1] <= pa3[0];
    pa3[2] <= pa3[1];
  end

  instruction_sequencer #(.PC_RESET(32'h0), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .run(run3),
    .imem_addr(imem_addr3), .imem_rd_en(imem_rd_en3), .imem_rdata(imem_rdata3),
    .ir(ir3), .cnt_set(cnt_set3), .stop(stop3), .ins_JAL(ins_jal3), .IM(im3),
    .step(step3), .exec_en(exec_en3), .pc(pc3), .pc_link(pc_link3),
    .retire(retire3), .halted(halted3)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] nxt;
    logic [1:0]  last;
  } exp_t;
  exp_t sbq[$];

  task automatic load_add(input logic [31:0] addr, input logic [1:0] c);
    exp_t e;
    mem[addr[9:2]] = op_add(c);
    e.pc = addr; e.nxt = addr + 32'd4; e.last = c;
    sbq.push_back(e);
  endtask

  task automatic load_jal(input logic [31:0] addr, input logic [19:0] imm);
    exp_t e;
    mem[addr[9:2]] = op_jal(imm);
    e.pc = addr; e.nxt = addr + {{11{imm[19]}}, imm, 1'b0}; e.last = 2'd0;
    sbq.push_back(e);
  endtask

  logic [31:0] nxt_exp;
  bit          nxt_pend = 1'b0;

  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (nxt_pend) begin
      chk("next_pc", pc, nxt_exp);
      nxt_pend = 1'b0;
    end
    if (!rst && retire) begin
      n_ret++;
      if (sbq.size() == 0) begin
        chk("unexpected_retire", 32'(retire), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("retire_pc", pc, e.pc);
        chk("retire_pc_link", pc_link, e.pc + 32'd4);
        chk("retire_step", 32'(step), 32'(e.last));
        nxt_exp  = e.nxt;
        nxt_pend = 1'b1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset1();
    rst = 1'b1;
    run = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic wait_ret(input int target, input int budget);
    int k = 0;
    while (n_ret < target && k < budget) begin
      tick();
      k++;
    end
    chk("retire_count", 32'(n_ret), 32'(target));
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      tick();
      k++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic hold_halted(input logic [31:0] exp_pc);
    int fetches = 0;
    int not_halt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_rd_en) fetches++;
      if (!halted) not_halt++;
    end
    chk("halt_no_fetch", 32'(fetches), 32'd0);
    chk("halt_sticky", 32'(not_halt), 32'd0);
    chk("halt_pc", pc, exp_pc);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 16; i++) mem3[i] = 32'hFFFF_FFFF;

    // Program 1: timing of first ALU op, forward JAL, backward JAL to 0xFFFFFFFC, wrap to 0.
    reset1();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_flags", {28'd0, imem_rd_en, exec_en, retire, halted}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_pc_link", pc_link, 32'h4);
    load_add(32'h00, 2'd2);
    load_add(32'h04, 2'd0);
    load_add(32'h08, 2'd1);
    load_add(32'h0C, 2'd3);
    load_jal(32'h10, 20'h00008);
    load_jal(32'h20, 20'hFFFEE);
    load_add(32'hFFFF_FFFC, 2'd1);
    run = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("c%0d_rd_en", c), 32'(imem_rd_en), 32'(c == 1 || c == 7));
      chk($sformatf("c%0d_exec_en", c), 32'(exec_en), 32'(c >= 4 && c <= 6));
      chk($sformatf("c%0d_retire", c), 32'(retire), 32'(c == 6));
      if (c >= 4 && c <= 6) chk($sformatf("c%0d_step", c), 32'(step), 32'(c - 4));
    end
    chk("c2_ir_loaded", ir, op_add(2'd2));
    mem[0] = 32'hFFFF_FFFF;
    wait_ret(7, 200);
    wait_halt(20);
    hold_halted(32'h0);

    // Program 2: JAL +16 to 0x10, JAL -8 back to 0x08, undecodable word there.
    reset1();
    chk("rst2_halted", 32'(halted), 32'd0);
    load_jal(32'h00, 20'h00008);
    load_jal(32'h10, 20'hFFFFC);
    k = n_ret;
    run = 1'b1;
    wait_ret(k + 2, 100);
    wait_halt(20);
    chk("halt_ir", ir, 32'hFFFF_FFFF);
    hold_halted(32'h8);
    chk("halt_ret_count", 32'(n_ret), 32'(k + 2));

    // Program 3: run dropped during step 1 of a cnt_set=3 op.
    reset1();
    load_add(32'h00, 2'd3);
    k = n_ret;
    run = 1'b1;
    for (int i = 0; i < 20 && !(exec_en && step == 2'd1); i++) tick();
    chk("drop_at_step1", {30'd0, step}, 32'd1);
    run = 1'b0;
    wait_ret(k + 1, 10);
    begin
      int fetches = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (imem_rd_en || exec_en) fetches++;
      end
      chk("idle_after_drop", 32'(fetches), 32'd0);
    end
    chk("idle_pc", pc, 32'h4);
    run = 1'b1;
    tick();
    chk("resume_rd_en", 32'(imem_rd_en), 32'd1);
    chk("resume_addr", imem_addr, 32'h4);
    wait_halt(10);
    chk("sbq_empty", 32'(sbq.size()), 32'd0);
    rst = 1'b1;
    run = 1'b0;

    // MEM_LAT=3: 6-cycle FETCH-to-FETCH for cnt_set=0, then reset during WAIT.
    mem3[0] = op_add(2'd0);
    mem3[1] = op_add(2'd1);
    rst3 = 1'b1;
    tick();
    tick();
    rst3 = 1'b0;
    cyc = 0;
    run3 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("l3_c%0d_rd_en", c), 32'(imem_rd_en3), 32'(c == 1 || c == 7));
      chk($sformatf("l3_c%0d_exec", c), 32'(exec_en3), 32'(c == 6));
      chk($sformatf("l3_c%0d_retire", c), 32'(retire3), 32'(c == 6));
    end
    chk("l3_pc_adv", pc3, 32'h4);
    rst3 = 1'b1;
    tick();
    chk("l3_rst_pc", pc3, 32'h0);
    chk("l3_rst_ir", ir3, 32'h0);
    chk("l3_rst_step", 32'(step3), 32'd0);
    chk("l3_rst_flags", {28'd0, imem_rd_en3, exec_en3, retire3, halted3}, 32'd0);
    chk("l3_rst_pc_link", pc_link3, 32'h4);
    rst3 = 1'b0;
    run3 = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (ir3 != 32'h0 || imem_rd_en3 || retire3) bad++;
      end
      chk("l3_stale_ignored", 32'(bad), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
